exu: RTL and testbench

- Execute stage of the in-order NPC pipeline. Sits directly downstream of the register-fetch stage and upstream of the LSU.
- Registers the RFU→EXU bus, computes the 8-op ALU result, and selects the writeback value.
- Raises a single-cycle branch redirect for taken branches and jumps. Publishes hazard info (exu_valid, exu_rd, exu_csr_addr) back to RFU for stall detection.

---
 rtl/exu_pkg.sv | 56 +++++
 rtl/exu_if.sv | 26 ++
 rtl/exu_alu.sv | 27 ++
 rtl/exu.sv | 97 +++++++++
 tb/tb_exu.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - Shared types and constants for the EXU pipeline stage
// Holds the ALU opcode encoding and the packed layouts of the RFU->EXU and
// EXU->LSU stage buses. No ports.
package exu_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_SLL = 3'd2;
    localparam logic [2:0] ALU_OP_SRL = 3'd3;
    localparam logic [2:0] ALU_OP_SRA = 3'd4;
    localparam logic [2:0] ALU_OP_XOR = 3'd5;
    localparam logic [2:0] ALU_OP_OR  = 3'd6;
    localparam logic [2:0] ALU_OP_AND = 3'd7;

    localparam int EXCP_WIDTH = 5;

    // Decoded instruction plus operands as delivered by the register-fetch stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [2:0]  alu_op;
        logic [31:0] rs2_value;
        logic [31:0] final_result;  // precomputed writeback value (e.g. snpc for jumps)
        logic        res_from_pre;
        logic        res_from_mem;
        logic [3:0]  mem_re;
        logic [3:0]  mem_we;
        logic        gr_we;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        xret_flush;
        logic        branch;
    } rfu_exu_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
        logic        res_from_mem;
        logic [3:0]  mem_re;
        logic [3:0]  mem_we;
        logic        gr_we;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        xret_flush;
    } exu_lsu_bus_t;

    localparam int RFU_EXU_BUS_WIDTH = $bits(rfu_exu_bus_t);
    localparam int EXU_LSU_BUS_WIDTH = $bits(exu_lsu_bus_t);

endpackage

// File: rtl/exu_if.sv
// rtl/exu_if.sv - Pipeline link of the EXU: RFU->EXU input and EXU->LSU output
// master: the surrounding pipeline (drives rfu_* and lsu_ready_i)
// slave : the EXU (drives exu_ready_o, exu_lsu_bus_o, exu_excp_bus_o, valid_o)
interface exu_if;
    import exu_pkg::*;

    logic                  rfu_valid_i;
    rfu_exu_bus_t          rfu_exu_bus_i;
    logic [EXCP_WIDTH-1:0] rfu_excp_bus_i;
    logic                  exu_ready_o;
    logic                  lsu_ready_i;
    exu_lsu_bus_t          exu_lsu_bus_o;
    logic [EXCP_WIDTH-1:0] exu_excp_bus_o;
    logic                  valid_o;

    modport master (
        output rfu_valid_i, rfu_exu_bus_i, rfu_excp_bus_i, lsu_ready_i,
        input  exu_ready_o, exu_lsu_bus_o, exu_excp_bus_o, valid_o
    );

    modport slave (
        input  rfu_valid_i, rfu_exu_bus_i, rfu_excp_bus_i, lsu_ready_i,
        output exu_ready_o, exu_lsu_bus_o, exu_excp_bus_o, valid_o
    );

endinterface

// File: rtl/exu_alu.sv
// rtl/exu_alu.sv - Combinational 8-op ALU of the execute stage
// Ports: op (ALU_OP_* code), a/b (32-bit operands), y (32-bit result).
module exu_alu
    import exu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_OP_ADD: y = a + b;
            ALU_OP_SUB: y = a - b;
            ALU_OP_SLL: y = a << b[4:0];
            ALU_OP_SRL: y = a >> b[4:0];
            ALU_OP_SRA: y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OP_XOR: y = a ^ b;
            ALU_OP_OR:  y = a | b;
            ALU_OP_AND: y = a & b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/exu.sv
// rtl/exu.sv - Execute stage: stage register, ALU, writeback select, branch redirect
// Ports: clock, reset (async, active-low), excp_flush/mret_flush (kill held
// instruction), pipe (exu_if.slave link RFU->EXU->LSU), branch_flush_o /
// branch_target_o (one-shot redirect), exu_valid_o / exu_rd_o /
// exu_csr_addr_o (hazard info back to RFU).
module exu
    import exu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic        mret_flush,
    exu_if.slave        pipe,
    output logic        branch_flush_o,
    output logic [31:0] branch_target_o,
    output logic        exu_valid_o,
    output logic [4:0]  exu_rd_o,
    output logic [11:0] exu_csr_addr_o
);

    logic                  valid;
    logic                  redirect_done;
    rfu_exu_bus_t          bus_r;
    logic [EXCP_WIDTH-1:0] excp_r;
    logic [31:0]           alu_result;
    logic                  flush;
    logic                  accept;
    exu_lsu_bus_t          lsu_bus;

    assign flush            = excp_flush | mret_flush;
    assign pipe.exu_ready_o = !valid || pipe.lsu_ready_i;
    assign accept           = pipe.rfu_valid_i && pipe.exu_ready_o;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid         <= 1'b0;
            redirect_done <= 1'b0;
        end else begin
            if (flush)                  valid <= 1'b0;
            else if (accept)            valid <= 1'b1;
            else if (pipe.lsu_ready_i)  valid <= 1'b0;

            // Remember that the redirect already fired so a stalled branch
            // does not redirect the front end a second time.
            if (flush || accept)                           redirect_done <= 1'b0;
            else if (branch_flush_o && !pipe.lsu_ready_i)  redirect_done <= 1'b1;
            else if (pipe.lsu_ready_i)                     redirect_done <= 1'b0;
        end
    end

    // Payload registers carry no reset; every consumer is qualified by valid.
    always_ff @(posedge clock) begin
        if (accept) begin
            bus_r  <= pipe.rfu_exu_bus_i;
            excp_r <= pipe.rfu_excp_bus_i;
        end
    end

    exu_alu u_alu (
        .op (bus_r.alu_op),
        .a  (bus_r.src1),
        .b  (bus_r.src2),
        .y  (alu_result)
    );

    always_comb begin
        lsu_bus              = '0;
        lsu_bus.pc           = bus_r.pc;
        lsu_bus.rd           = bus_r.rd;
        lsu_bus.result       = bus_r.res_from_pre ? bus_r.final_result : alu_result;
        lsu_bus.store_data   = bus_r.rs2_value;
        lsu_bus.res_from_mem = bus_r.res_from_mem;
        lsu_bus.mem_re       = bus_r.mem_re;
        lsu_bus.mem_we       = bus_r.mem_we;
        lsu_bus.gr_we        = bus_r.gr_we;
        lsu_bus.csr_we       = bus_r.csr_we;
        lsu_bus.csr_addr     = bus_r.csr_addr;
        lsu_bus.csr_wdata    = bus_r.csr_wdata;
        lsu_bus.xret_flush   = bus_r.xret_flush;
    end

    // Outputs are forced to zero while idle so reset and bubbles look clean.
    assign pipe.exu_lsu_bus_o  = valid ? lsu_bus : '0;
    assign pipe.exu_excp_bus_o = valid ? excp_r : '0;
    assign pipe.valid_o        = valid && !flush;

    // A flush in the same cycle as a pending redirect wins.
    assign branch_flush_o  = valid && bus_r.branch && !redirect_done && !flush;
    assign branch_target_o = (valid && bus_r.branch) ? {alu_result[31:1], 1'b0} : RESET_PC;

    assign exu_valid_o    = valid && ((bus_r.gr_we && (bus_r.rd != 5'd0)) || bus_r.csr_we);
    assign exu_rd_o       = (exu_valid_o && bus_r.gr_we)  ? bus_r.rd       : 5'd0;
    assign exu_csr_addr_o = (exu_valid_o && bus_r.csr_we) ? bus_r.csr_addr : 12'd0;

endmodule

// File: tb/tb_exu.sv
// tb/tb_exu.sv - Scoreboard testbench for the exu execute stage
module tb_exu;
    import exu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        excp_flush = 1'b0;
    logic        mret_flush = 1'b0;
    logic        branch_flush_o;
    logic [31:0] branch_target_o;
    logic        exu_valid_o;
    logic [4:0]  exu_rd_o;
    logic [11:0] exu_csr_addr_o;

    exu_if pipe ();

    exu #(.RESET_PC(32'h8000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .excp_flush      (excp_flush),
        .mret_flush      (mret_flush),
        .pipe            (pipe.slave),
        .branch_flush_o  (branch_flush_o),
        .branch_target_o (branch_target_o),
        .exu_valid_o     (exu_valid_o),
        .exu_rd_o        (exu_rd_o),
        .exu_csr_addr_o  (exu_csr_addr_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        ev;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tgt_q[$];
    exp_t        mon_e;
    logic [31:0] mon_t;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          p0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rfu_exu_bus_t mk(input logic [2:0] op, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [4:0] rd,
                                        input logic gr_we, input logic br);
        rfu_exu_bus_t b;
        b        = '0;
        b.pc     = 32'h8000_1000;
        b.alu_op = op;
        b.src1   = s1;
        b.src2   = s2;
        b.rd     = rd;
        b.gr_we  = gr_we;
        b.branch = br;
        return b;
    endfunction

    // Presents one instruction for a single cycle; caller guarantees exu_ready_o.
    task automatic send(input rfu_exu_bus_t b);
        pipe.rfu_valid_i    = 1'b1;
        pipe.rfu_exu_bus_i  = b;
        pipe.rfu_excp_bus_i = 5'h0;
        @(posedge clock);
        #1;
        pipe.rfu_valid_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares every transfer to LSU and every redirect pulse.
    initial begin
        forever begin
            @(negedge clock);
            if (pipe.valid_o && pipe.lsu_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h expected none", pipe.exu_lsu_bus_o.result);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", pipe.exu_lsu_bus_o.result, mon_e.result);
                    check("exu_rd", {27'd0, exu_rd_o}, {27'd0, mon_e.rd});
                    check("exu_valid", {31'd0, exu_valid_o}, {31'd0, mon_e.ev});
                end
            end
            if (branch_flush_o) begin
                pulses++;
                if (tgt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: got target %h expected no pulse", branch_target_o);
                end else begin
                    mon_t = tgt_q.pop_front();
                    check("branch_target", branch_target_o, mon_t);
                end
            end
        end
    end

    logic [2:0]  v_op [7] = '{ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_XOR, ALU_OP_OR, ALU_OP_AND};
    logic [31:0] v_a  [7] = '{32'd5, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_0000, 32'hF0F0_F0F0};
    logic [31:0] v_b  [7] = '{32'd7, 32'd33, 32'd4, 32'd4, 32'hFF00_FF00, 32'h0000_0F0F, 32'hFF00_FF00};
    logic [31:0] v_y  [7] = '{32'hFFFF_FFFE, 32'd2, 32'h0800_0000, 32'hF800_0000, 32'h0FF0_0FF0, 32'hF0F0_0F0F, 32'hF000_F000};

    initial begin
        rfu_exu_bus_t b;
        pipe.rfu_valid_i    = 1'b0;
        pipe.rfu_exu_bus_i  = '0;
        pipe.rfu_excp_bus_i = '0;
        pipe.lsu_ready_i    = 1'b1;
        #1 reset = 1'b0;
        #11;
        check("rst_valid_o", {31'd0, pipe.valid_o}, 32'd0);
        check("rst_branch_flush", {31'd0, branch_flush_o}, 32'd0);
        check("rst_branch_target", branch_target_o, 32'h8000_0000);
        check("rst_exu_valid", {31'd0, exu_valid_o}, 32'd0);
        check("rst_bus_result", pipe.exu_lsu_bus_o.result, 32'd0);
        check("rst_exu_ready", {31'd0, pipe.exu_ready_o}, 32'd1);
        step();
        reset = 1'b1;
        step();

        // ADD with one-cycle latency
        exp_q.push_back('{32'd12, 5'd3, 1'b1});
        send(mk(ALU_OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        check("add_latency_valid_o", {31'd0, pipe.valid_o}, 32'd1);

        // Remaining ops back to back
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{v_y[i], 5'(i + 1), 1'b1});
            send(mk(v_op[i], v_a[i], v_b[i], 5'(i + 1), 1'b1, 1'b0));
        end
        step();
        check("b2b_drained", exp_q.size(), 32'd0);

        // JAL: target from ALU, writeback from precomputed snpc
        p0 = pulses;
        b = mk(ALU_OP_ADD, 32'h8000_0010, 32'h20, 5'd1, 1'b1, 1'b1);
        b.res_from_pre = 1'b1;
        b.final_result = 32'h8000_0014;
        exp_q.push_back('{32'h8000_0014, 5'd1, 1'b1});
        tgt_q.push_back(32'h8000_0030);
        send(b);
        step();
        step();
        check("jal_pulses", pulses - p0, 32'd1);

        // Branch held four cycles by LSU back-pressure
        pipe.lsu_ready_i = 1'b0;
        p0 = pulses;
        exp_q.push_back('{32'h8000_0111, 5'd0, 1'b0});
        tgt_q.push_back(32'h8000_0110);
        send(mk(ALU_OP_ADD, 32'h8000_0100, 32'h11, 5'd0, 1'b0, 1'b1));
        for (int k = 0; k < 4; k++) begin
            check("hold_valid_o", {31'd0, pipe.valid_o}, 32'd1);
            check("hold_result", pipe.exu_lsu_bus_o.result, 32'h8000_0111);
            check("hold_pulse", {31'd0, branch_flush_o}, (k == 0) ? 32'd1 : 32'd0);
            step();
        end
        pipe.lsu_ready_i = 1'b1;
        #1;
        check("release_valid_o", {31'd0, pipe.valid_o}, 32'd1);
        check("release_pulse", {31'd0, branch_flush_o}, 32'd0);
        step();
        check("after_release_valid_o", {31'd0, pipe.valid_o}, 32'd0);
        check("hold_pulses", pulses - p0, 32'd1);
        check("hold_drained", exp_q.size(), 32'd0);

        // Exception flush on the same cycle as the pending redirect
        pipe.lsu_ready_i = 1'b0;
        p0 = pulses;
        send(mk(ALU_OP_ADD, 32'h8000_0200, 32'h8, 5'd4, 1'b1, 1'b1));
        excp_flush = 1'b1;
        #1;
        check("flush_pulse", {31'd0, branch_flush_o}, 32'd0);
        check("flush_valid_o", {31'd0, pipe.valid_o}, 32'd0);
        step();
        excp_flush = 1'b0;
        #1;
        check("post_flush_valid_o", {31'd0, pipe.valid_o}, 32'd0);
        check("post_flush_exu_valid", {31'd0, exu_valid_o}, 32'd0);
        check("flush_pulses", pulses - p0, 32'd0);
        pipe.lsu_ready_i = 1'b1;

        // Store: no GPR write, so no hazard
        b = mk(ALU_OP_ADD, 32'h1000, 32'h8, 5'd5, 1'b0, 1'b0);
        b.mem_we    = 4'hF;
        b.rs2_value = 32'hDEAD_BEEF;
        exp_q.push_back('{32'h1008, 5'd0, 1'b0});
        send(b);
        check("store_data", pipe.exu_lsu_bus_o.store_data, 32'hDEAD_BEEF);
        check("store_mem_we", {28'd0, pipe.exu_lsu_bus_o.mem_we}, 32'hF);
        step();

        // Reset asserted while a branch is held
        pipe.lsu_ready_i = 1'b0;
        p0 = pulses;
        send(mk(ALU_OP_ADD, 32'h8000_0300, 32'h4, 5'd6, 1'b1, 1'b1));
        reset = 1'b0;
        #1;
        check("midrst_valid_o", {31'd0, pipe.valid_o}, 32'd0);
        check("midrst_pulse", {31'd0, branch_flush_o}, 32'd0);
        check("midrst_target", branch_target_o, 32'h8000_0000);
        check("midrst_exu_valid", {31'd0, exu_valid_o}, 32'd0);
        step();
        reset = 1'b1;
        pipe.lsu_ready_i = 1'b1;
        exp_q.push_back('{32'd123, 5'd2, 1'b1});
        send(mk(ALU_OP_ADD, 32'd100, 32'd23, 5'd2, 1'b1, 1'b0));
        check("postrst_latency_valid_o", {31'd0, pipe.valid_o}, 32'd1);
        step();
        check("final_exp_empty", exp_q.size(), 32'd0);
        check("final_tgt_empty", tgt_q.size(), 32'd0);
        check("midrst_pulses", pulses - p0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
